record_buffer: RTL
==================

RECORD_BUFFER -- requirements
Module: record_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, record data width.
REQ-002 SHALL have parameter DEPTH, default 4, entries per channel; power of two.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port writeRegP, input, 1, P-channel write enable from the information controller (level signal).
REQ-006 SHALL have port writeRegQ, input, 1, Q-channel write enable from the information controller (level signal).
REQ-007 SHALL have port dataIn, input, DATA_W, record value to store.
REQ-008 SHALL have port readReq, input, 1, read request.
REQ-009 SHALL have port readSel, input, 1, read channel: 0 = P, 1 = Q.
REQ-010 SHALL have port dataOut, output, DATA_W, registered read data.
REQ-011 SHALL have port dataValid, output, 1, one-cycle pulse qualifying dataOut.
REQ-012 SHALL have ports fullP, emptyP, fullQ, emptyQ, output, 1 each, channel status.
REQ-013 SHALL have ports countP, countQ, output, log2(DEPTH)+1 each, stored entry counts.
REQ-014 SHALL have port overflow, output, 1, sticky dropped-write flag.

Function
REQ-015 Each of writeRegP and writeRegQ SHALL be rising-edge detected against its value in the previous cycle; each 0->1 transition SHALL produce exactly one write of dataIn, sampled in that same cycle.
REQ-016 Holding writeRegP or writeRegQ high SHALL NOT produce further writes.
REQ-017 Simultaneous P and Q edges SHALL write the same dataIn into both channels in the same cycle.
REQ-018 Each channel SHALL be a FIFO of DEPTH entries with wrap-around read and write pointers.
REQ-019 A write to a full channel SHALL be dropped, leave that channel unchanged, and set overflow.
REQ-020 overflow SHALL remain 1 until reset.
REQ-021 A readReq to a non-empty channel selected by readSel SHALL pop the oldest entry; dataOut SHALL show that entry and dataValid SHALL be 1 in the following cycle (latency 1).
REQ-022 A readReq to an empty channel SHALL be ignored: dataValid stays 0 and dataOut holds its previous value.
REQ-023 A read and a write to the same full channel in the same cycle SHALL both be accepted, leaving count unchanged and overflow not set.
REQ-024 A read and a write to the same empty channel in the same cycle SHALL accept the write and ignore the read (no fall-through).
REQ-025 fullX SHALL equal (countX == DEPTH), emptyX SHALL equal (countX == 0), and both SHALL be registered-state derived with no combinational path from the inputs.

Reset
REQ-026 Reset SHALL force countP = countQ = 0, all pointers = 0, dataOut = 0, dataValid = 0, overflow = 0, and both edge-detect history registers = 0, so emptyP = emptyQ = 1 and fullP = fullQ = 0.
REQ-027 Reset asserted mid-operation SHALL discard all stored entries immediately, without waiting for a clock edge.
REQ-028 A write enable already high when reset deasserts SHALL count as a rising edge on the first clock after deassertion.

Structure
REQ-029 DATA_W and DEPTH defaults, and the channel-select encoding (P = 0, Q = 1), SHALL live in the shared healthcare package used by the information controller.
REQ-030 The single-channel FIFO SHALL be a sub-module named record_fifo, instantiated twice, with the edge detection, read steering and overflow logic at top level.

Verification
REQ-031 Reset, then pulse writeRegP with dataIn = 0xC0, then readReq with readSel = 0 -> dataOut = 0xC0, dataValid high for 1 cycle, emptyP = 1.
REQ-032 Hold writeRegQ high for 5 cycles with dataIn = 0x40 -> countQ = 1 only.
REQ-033 Write 0x01..0x05 to P via 5 edges -> countP = 4, fullP = 1, overflow = 1; reads return 0x01, 0x02, 0x03, 0x04 in order.
REQ-034 Same-cycle edges on P and Q with dataIn = 0x7E -> countP = countQ = 1; reading each channel returns 0x7E.
REQ-035 With P full, a same-cycle read and write of 0x99 -> countP stays 4, overflow stays 0, and 0x99 is the last value read.
REQ-036 Assert reset asynchronously between clock edges with 2 entries stored -> counts go to 0 and empty flags go to 1 before the next edge; a readReq then gives dataValid = 0.

Source files
------------

// File: rtl/record_buffer_pkg.sv
// Shared healthcare record-path definitions: default record geometry and the
// read-channel select encoding used by the information controller.
package record_buffer_pkg;

    localparam int unsigned REC_DATA_W = 8;
    localparam int unsigned REC_DEPTH  = 4;

    typedef enum logic {
        CH_P = 1'b0,
        CH_Q = 1'b1
    } chan_sel_e;

endpackage

// File: rtl/record_buffer_fifo.sv
// Single-channel record FIFO: DEPTH entries, wrap-around pointers, occupancy
// counter. A pop on empty is ignored; a push on full is accepted only alongside a pop.
module record_fifo
    import record_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = REC_DATA_W,
    parameter int unsigned DEPTH  = REC_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic [DATA_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     push_ok_o,
    output logic                     pop_ok_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, empty, push_ok, pop_ok;

    // Flags decode the count register only, so no input reaches them combinationally.
    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop_i && !empty;
    assign push_ok = push_i && (!full || pop_ok);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; clearing the pointers and count is what discards entries.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign full_o    = full;
    assign empty_o   = empty;
    assign push_ok_o = push_ok;
    assign pop_ok_o  = pop_ok;

endmodule

// File: rtl/record_buffer.sv
// Two-channel (P/Q) record buffer: edge-detected write enables, steered reads
// with one-cycle registered data, and a sticky overflow flag for dropped writes.
module record_buffer
    import record_buffer_pkg::*;
#(
    parameter int unsigned DATA_W = REC_DATA_W,
    parameter int unsigned DEPTH  = REC_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     writeRegP,
    input  logic                     writeRegQ,
    input  logic [DATA_W-1:0]        dataIn,
    input  logic                     readReq,
    input  logic                     readSel,
    output logic [DATA_W-1:0]        dataOut,
    output logic                     dataValid,
    output logic                     fullP,
    output logic                     emptyP,
    output logic                     fullQ,
    output logic                     emptyQ,
    output logic [$clog2(DEPTH):0]   countP,
    output logic [$clog2(DEPTH):0]   countQ,
    output logic                     overflow
);

    logic              wr_p_hist_q, wr_q_hist_q;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              overflow_q, overflow_d;

    logic              edge_p, edge_q;
    logic              pop_p, pop_q;
    logic              pop_ok_p, pop_ok_q;
    logic              push_ok_p, push_ok_q;
    logic [DATA_W-1:0] head_p, head_q;
    chan_sel_e         rd_sel;

    // History resets to 0, so an enable already high at reset release counts as an edge.
    assign edge_p = writeRegP && !wr_p_hist_q;
    assign edge_q = writeRegQ && !wr_q_hist_q;

    assign rd_sel = chan_sel_e'(readSel);
    assign pop_p  = readReq && (rd_sel == CH_P);
    assign pop_q  = readReq && (rd_sel == CH_Q);

    record_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_p (
        .clk_i     (clock),
        .rst_i     (reset),
        .push_i    (edge_p),
        .pop_i     (pop_p),
        .data_i    (dataIn),
        .head_o    (head_p),
        .count_o   (countP),
        .full_o    (fullP),
        .empty_o   (emptyP),
        .push_ok_o (push_ok_p),
        .pop_ok_o  (pop_ok_p)
    );

    record_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo_q (
        .clk_i     (clock),
        .rst_i     (reset),
        .push_i    (edge_q),
        .pop_i     (pop_q),
        .data_i    (dataIn),
        .head_o    (head_q),
        .count_o   (countQ),
        .full_o    (fullQ),
        .empty_o   (emptyQ),
        .push_ok_o (push_ok_q),
        .pop_ok_o  (pop_ok_q)
    );

    always_comb begin
        data_out_d   = data_out_q;
        data_valid_d = pop_ok_p || pop_ok_q;
        if (pop_ok_p) begin
            data_out_d = head_p;
        end else if (pop_ok_q) begin
            data_out_d = head_q;
        end
        overflow_d = overflow_q
                   || (edge_p && !push_ok_p)
                   || (edge_q && !push_ok_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_p_hist_q  <= 1'b0;
            wr_q_hist_q  <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_p_hist_q  <= writeRegP;
            wr_q_hist_q  <= writeRegQ;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dataOut   = data_out_q;
    assign dataValid = data_valid_q;
    assign overflow  = overflow_q;

endmodule
